// File: rtl/octant_rom_arbiter.sv
// Round-robin share of one synchronous octant ROM read port among N_REQ ray processors.
// Grant is combinational (0-cycle); data returns ROM_LATENCY cycles later; losers simply hold req.
module octant_rom_arbiter #(
    parameter int N_REQ       = 4,
    parameter int ROM_LATENCY = 1,
    parameter int AW          = 32,
    parameter int DW          = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                en,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*AW-1:0] addr,
    output logic [N_REQ-1:0]    gnt,
    output logic [N_REQ-1:0]    rvalid,
    output logic [DW-1:0]       rdata,
    output logic [AW-1:0]       rom_addr,
    output logic                rom_ren,
    input  logic [DW-1:0]       rom_dout,
    output logic                busy,
    output logic [31:0]         conflict_cnt,
    input  logic                cnt_clr
);

    localparam int IW = $clog2(N_REQ);

    logic [IW-1:0]          r_rr_ptr;
    logic [ROM_LATENCY-1:0] r_tag_vld;
    logic [IW-1:0]          r_tag_id [ROM_LATENCY];
    logic [31:0]            r_conflict_cnt;

    logic                   w_found;
    logic [IW-1:0]          w_win;
    logic [IW-1:0]          w_cand;
    logic                   w_gnt_any;
    logic                   w_multi;
    logic [IW-1:0]          w_ptr_nxt;

    // Search begins at the pointer and wraps; the first pending request wins.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_cand  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_cand = IW'((int'(r_rr_ptr) + k) % N_REQ);
            if (!w_found && req[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end
    end

    // Reset gates the grant so the ROM port is quiet while held in reset.
    assign w_gnt_any = w_found & en & reset_n;

    always_comb begin
        gnt = '0;
        if (w_gnt_any) begin
            gnt[w_win] = 1'b1;
        end
    end

    assign rom_ren   = w_gnt_any;
    assign rom_addr  = w_gnt_any ? addr[int'(w_win)*AW +: AW] : '0;
    assign w_ptr_nxt = (int'(w_win) == N_REQ - 1) ? '0 : w_win + 1'b1;
    assign w_multi   = |(req & (req - N_REQ'(1)));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rr_ptr  <= '0;
            r_tag_vld <= '0;
            for (int k = 0; k < ROM_LATENCY; k++) begin
                r_tag_id[k] <= '0;
            end
        end else begin
            if (w_gnt_any) begin
                r_rr_ptr <= w_ptr_nxt;
            end
            r_tag_vld[0] <= w_gnt_any;
            r_tag_id[0]  <= w_win;
            for (int k = 1; k < ROM_LATENCY; k++) begin
                r_tag_vld[k] <= r_tag_vld[k-1];
                r_tag_id[k]  <= r_tag_id[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_conflict_cnt <= '0;
        end else if (cnt_clr) begin
            r_conflict_cnt <= '0;
        end else if (en && w_multi && (r_conflict_cnt != 32'hFFFF_FFFF)) begin
            r_conflict_cnt <= r_conflict_cnt + 32'd1;
        end
    end

    always_comb begin
        rvalid = '0;
        if (r_tag_vld[ROM_LATENCY-1]) begin
            rvalid[r_tag_id[ROM_LATENCY-1]] = 1'b1;
        end
    end

    assign rdata        = rom_dout;
    assign busy         = |r_tag_vld;
    assign conflict_cnt = r_conflict_cnt;

endmodule

// File: tb/tb_octant_rom_arbiter.sv
// Directed bench: default-latency arbiter plus a ROM_LATENCY=3 instance, each behind a ROM model.
module tb_octant_rom_arbiter;

    logic         clk;
    logic         rst_n, rst3_n;
    logic         en, en3, cnt_clr;
    logic [3:0]   req, req3;
    logic [127:0] addr, addr3;
    logic [3:0]   gnt, gnt3, rvalid, rvalid3;
    logic [31:0]  rdata, rdata3, rom_addr, rom_addr3, rom_dout, rom_dout3;
    logic         rom_ren, rom_ren3, busy, busy3;
    logic [31:0]  cnt, cnt3;
    logic [31:0]  a1, b1, b2, b3;

    int n_chk  = 0;
    int n_pass = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom_f(input logic [31:0] a);
        return (a * 32'd7) ^ 32'hC0DE_0000;
    endfunction

    // Synchronous ROM models: 1 and 3 edges from address sample to data.
    always @(posedge clk) begin
        a1 <= rom_addr;
        b1 <= rom_addr3;
        b2 <= b1;
        b3 <= b2;
    end
    assign rom_dout  = rom_f(a1);
    assign rom_dout3 = rom_f(b3);

    octant_rom_arbiter u_dut (
        .clk(clk), .reset_n(rst_n), .en(en), .req(req), .addr(addr),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .rom_addr(rom_addr),
        .rom_ren(rom_ren), .rom_dout(rom_dout), .busy(busy),
        .conflict_cnt(cnt), .cnt_clr(cnt_clr)
    );

    octant_rom_arbiter #(.ROM_LATENCY(3)) u_dut3 (
        .clk(clk), .reset_n(rst3_n), .en(en3), .req(req3), .addr(addr3),
        .gnt(gnt3), .rvalid(rvalid3), .rdata(rdata3), .rom_addr(rom_addr3),
        .rom_ren(rom_ren3), .rom_dout(rom_dout3), .busy(busy3),
        .conflict_cnt(cnt3), .cnt_clr(1'b0)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    // Advance one cycle; inputs change 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; rst3_n = 1'b0; en = 1'b1; en3 = 1'b1; cnt_clr = 1'b0;
        req = 4'b1111; req3 = 4'b0000; addr = '0; addr3 = '0;
        #2;
        chk("rst_gnt", gnt, 4'b0000);
        chk("rst_ren", rom_ren, 1'b0);
        chk("rst_addr", rom_addr, 32'h0);
        chk("rst_rvalid", rvalid, 4'b0000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_cnt", cnt, 32'h0);
        step();
        step();
        req = 4'b0000; rst_n = 1'b1; rst3_n = 1'b1;
        step();

        // Single read at default latency
        req = 4'b0001; addr[31:0] = 32'h10;
        #2;
        chk("rd_gnt", gnt, 4'b0001);
        chk("rd_addr", rom_addr, 32'h10);
        chk("rd_ren", rom_ren, 1'b1);
        step();
        req = 4'b0000;
        #2;
        chk("rd_rvalid", rvalid, 4'b0001);
        chk("rd_rdata", rdata, rom_f(32'h10));
        chk("rd_busy", busy, 1'b1);
        step();

        // Second read killed by reset in its return cycle
        req = 4'b0001; addr[31:0] = 32'h20;
        #2;
        chk("rd2_gnt", gnt, 4'b0001);
        step();
        req = 4'b0000;
        #2;
        chk("rd2_busy_pre", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rd2_busy_rst", busy, 1'b0);
        chk("rd2_rvalid_rst", rvalid, 4'b0000);
        step();
        rst_n = 1'b1;
        #2;
        chk("rd2_rvalid_after", rvalid, 4'b0000);
        step();

        // Full rotation with every requester asserted
        req = 4'b1111;
        for (int i = 0; i < 4; i++) addr[i*32 +: 32] = 32'h100 + i;
        for (int k = 0; k < 8; k++) begin
            #2;
            chk($sformatf("rot_gnt%0d", k), gnt, 4'b0001 << (k % 4));
            if (k > 0) begin
                chk($sformatf("rot_rv%0d", k), rvalid, 4'b0001 << ((k - 1) % 4));
                chk($sformatf("rot_rd%0d", k), rdata, rom_f(32'h100 + (k - 1) % 4));
            end
            step();
        end
        req = 4'b0000;
        #2;
        chk("rot_cnt", cnt, 32'd8);
        chk("rot_rv_last", rvalid, 4'b1000);
        step();

        // Move pointer to 2, then a lower pair must be reached by wrapping
        req = 4'b0010;
        #2;
        chk("skip_g1", gnt, 4'b0010);
        step();
        req = 4'b0011;
        #2;
        chk("skip_wrap0", gnt, 4'b0001);
        step();
        #2;
        chk("skip_then1", gnt, 4'b0010);
        step();
        req = 4'b0101;
        #2;
        chk("skip_r2_wins", gnt, 4'b0100);
        req = 4'b0001;
        #2;
        chk("skip_r2_drop", gnt, 4'b0001);
        chk("skip_addr", rom_addr, 32'h100);
        step();

        // Enable low: no grants, counter frozen, in-flight read still returns
        en = 1'b0; req = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            #2;
            chk($sformatf("en_gnt%0d", k), gnt, 4'b0000);
            chk($sformatf("en_ren%0d", k), rom_ren, 1'b0);
            if (k == 0) begin
                chk("en_rvalid", rvalid, 4'b0001);
                chk("en_rdata", rdata, rom_f(32'h100));
            end
            if (k == 1) chk("en_busy", busy, 1'b0);
            step();
        end
        #2;
        chk("en_cnt", cnt, 32'd10);
        en = 1'b1; req = 4'b0000;
        step();

        // Counter saturation and clear
        req = 4'b0011;
        force u_dut.r_conflict_cnt = 32'hFFFF_FFFD;
        #1;
        release u_dut.r_conflict_cnt;
        step();
        #2;
        chk("sat_inc", cnt, 32'hFFFF_FFFE);
        step();
        step();
        step();
        #2;
        chk("sat_hold", cnt, 32'hFFFF_FFFF);
        cnt_clr = 1'b1;
        step();
        #2;
        chk("sat_clr", cnt, 32'h0);
        cnt_clr = 1'b0;
        step();
        #2;
        chk("sat_restart", cnt, 32'h1);
        req = 4'b0000;
        step();

        // ROM_LATENCY=3: grants 1,3,0 back to back, returns in order
        addr3[1*32 +: 32] = 32'h31;
        addr3[3*32 +: 32] = 32'h33;
        addr3[0 +: 32]    = 32'h30;
        req3 = 4'b0010;
        #2;
        chk("l3_g1", gnt3, 4'b0010);
        step();
        req3 = 4'b1000;
        #2;
        chk("l3_g3", gnt3, 4'b1000);
        step();
        req3 = 4'b0001;
        #2;
        chk("l3_g0", gnt3, 4'b0001);
        chk("l3_rv_early", rvalid3, 4'b0000);
        step();
        req3 = 4'b0000;
        #2;
        chk("l3_rv1", rvalid3, 4'b0010);
        chk("l3_rd1", rdata3, rom_f(32'h31));
        step();
        #2;
        chk("l3_rv3", rvalid3, 4'b1000);
        chk("l3_rd3", rdata3, rom_f(32'h33));
        step();
        #2;
        chk("l3_rv0", rvalid3, 4'b0001);
        chk("l3_rd0", rdata3, rom_f(32'h30));
        chk("l3_busy", busy3, 1'b1);
        step();
        #2;
        chk("l3_idle", busy3, 1'b0);
        chk("l3_rv_none", rvalid3, 4'b0000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
